// File: rtl/instr_mem_pkg.sv
// Shared types and default sizing for the loadable instruction memory.
package instr_mem_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  localparam int              DEF_DATA_W   = 16;
  localparam int              DEF_ADDR_W   = 16;
  localparam int              DEF_DEPTH    = 128;
  localparam int              DEF_BANKS    = 4;
  localparam logic [15:0]     DEF_NOP_WORD = 16'hBF00;

endpackage

// File: rtl/instr_bank_ram.sv
// Flat program storage for all banks, addressed as {bank, word}.
// One write port, one registered read port; contents are never reset.
module instr_bank_ram #(
  parameter int DATA_W = 16,
  parameter int AW     = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];
  logic [DATA_W-1:0] rdata_q;

  // Write port: one word per cycle while loading.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its value when no read is requested.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/prog_instruction_mem.sv
// Run-time loadable, multi-bank instruction memory.
// Handshake: a load beat transfers on a rising edge where load_valid and
// load_ready are both high; load_ready is high exactly while in LOAD, and
// load_data/load_last are only looked at on such a beat.
// Fetches are accepted only in IDLE and answered one cycle later.
module prog_instruction_mem
  import instr_mem_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter int                BANKS    = DEF_BANKS,
  parameter logic [DATA_W-1:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(BANKS)-1:0] bank_sel,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     load_last,
  output logic                     load_ready,
  output logic                     load_done,
  input  logic                     fetch_req,
  input  logic [ADDR_W-1:0]        fetch_addr,
  output logic                     instr_valid,
  output logic [DATA_W-1:0]        instruction,
  output logic                     fetch_fault,
  output logic                     busy
);

  localparam int BANK_W = $clog2(BANKS);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LEN_W  = PTR_W + 1;
  localparam int RAM_AW = BANK_W + PTR_W;

  state_e            state_q, state_d;
  logic [BANK_W-1:0] load_bank_q, load_bank_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]  prog_len_q [BANKS];
  logic [LEN_W-1:0]  prog_len_d [BANKS];
  logic              load_done_q, load_done_d;
  logic              instr_valid_q, instr_valid_d;
  logic              nop_sel_q, nop_sel_d;

  logic              beat, final_beat, fetch_acc, fetch_hit;
  logic [ADDR_W:0]   len_ext, addr_ext;
  logic [DATA_W-1:0] ram_rdata;

  // State and datapath registers. A reset that lands in LOAD only aborts the
  // load and keeps the bank lengths; a reset seen in IDLE clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      load_bank_q   <= '0;
      wr_ptr_q      <= '0;
      load_done_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      nop_sel_q     <= 1'b1;
      if (state_q == ST_IDLE) begin
        for (int i = 0; i < BANKS; i++) prog_len_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      load_bank_q   <= load_bank_d;
      wr_ptr_q      <= wr_ptr_d;
      load_done_q   <= load_done_d;
      instr_valid_q <= instr_valid_d;
      nop_sel_q     <= nop_sel_d;
      prog_len_q    <= prog_len_d;
    end
  end

  // Next-state logic: enter LOAD on load_start, leave on the final beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load_start) state_d = ST_LOAD;
      ST_LOAD: if (final_beat) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state only.
  always_comb begin
    load_ready = (state_q == ST_LOAD);
    busy       = (state_q == ST_LOAD);
  end

  // Load datapath: write pointer, load bank latch and program length update.
  always_comb begin
    beat        = load_valid & load_ready;
    final_beat  = beat & (load_last | (wr_ptr_q == PTR_W'(DEPTH - 1)));
    load_bank_d = load_bank_q;
    wr_ptr_d    = wr_ptr_q;
    prog_len_d  = prog_len_q;
    if (state_q == ST_IDLE && load_start) begin
      load_bank_d = bank_sel;
      wr_ptr_d    = '0;
    end else if (beat) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (final_beat) prog_len_d[load_bank_q] = LEN_W'(wr_ptr_q) + 1'b1;
    load_done_d = final_beat;
  end

  // Fetch path: unsigned compare without wrap, NOOP selection for faults.
  always_comb begin
    fetch_acc     = fetch_req & (state_q == ST_IDLE);
    len_ext       = (ADDR_W + 1)'(prog_len_q[bank_sel]);
    addr_ext      = {1'b0, fetch_addr};
    fetch_hit     = (addr_ext < len_ext);
    instr_valid_d = fetch_acc;
    nop_sel_d     = fetch_acc ? ~fetch_hit : nop_sel_q;
  end

  instr_bank_ram #(
    .DATA_W (DATA_W),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (beat),
    .waddr ({load_bank_q, wr_ptr_q}),
    .wdata (load_data),
    .re    (fetch_acc & fetch_hit),
    .raddr ({bank_sel, fetch_addr[PTR_W-1:0]}),
    .rdata (ram_rdata)
  );

  assign load_done   = load_done_q;
  assign instr_valid = instr_valid_q;
  assign instruction = nop_sel_q ? NOP_WORD : ram_rdata;
  assign fetch_fault = instr_valid_q & nop_sel_q;

endmodule

// File: tb/tb_prog_instruction_mem.sv
// Directed bench for prog_instruction_mem: load banks, fetch, check faults.
module tb_prog_instruction_mem;

  localparam logic [15:0] NOP = 16'hBF00;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  bank_sel;
  logic        load_start, load_valid, load_last;
  logic [15:0] load_data;
  logic        load_ready, load_done;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        instr_valid, fetch_fault, busy;
  logic [15:0] instruction;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference program image and lengths, maintained by the driver tasks.
  logic [15:0] exp_mem [4][128];
  int          exp_len [4];
  logic [15:0] prog_buf [128];

  prog_instruction_mem dut (
    .clk         (clk),
    .reset       (reset),
    .bank_sel    (bank_sel),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .fetch_fault (fetch_fault),
    .busy        (busy)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single fetch; checks the response against the reference image.
  task automatic fetch_chk(input int bank, input int addr, input string tag);
    logic        hit;
    logic [15:0] exp_i;
    bank_sel   = 2'(bank);
    fetch_addr = 16'(addr);
    fetch_req  = 1'b1;
    tick();
    fetch_req = 1'b0;
    hit   = (addr < exp_len[bank]);
    exp_i = hit ? exp_mem[bank][addr] : NOP;
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_instr"}, 32'(instruction), 32'(exp_i));
    check({tag, "_fault"}, 32'(fetch_fault), 32'(!hit));
  endtask

  // Program a bank from prog_buf. Optional gaps (with a stray load_last while
  // load_valid is low), fetch_req held during LOAD, and a fetch of addr 0
  // issued together with load_start.
  task automatic load_prog(input int bank, input int n, input bit use_last,
                           input bit gaps, input bit hold_fetch, input bit start_fetch);
    int done_cnt = 0;
    logic [15:0] old_w0;
    old_w0     = (exp_len[bank] > 0) ? exp_mem[bank][0] : NOP;
    bank_sel   = 2'(bank);
    load_start = 1'b1;
    fetch_req  = start_fetch;
    fetch_addr = 16'd0;
    tick();
    load_start = 1'b0;
    check("load_ready_rise", 32'(load_ready), 32'd1);
    check("busy_rise", 32'(busy), 32'd1);
    if (start_fetch) begin
      check("start_fetch_valid", 32'(instr_valid), 32'd1);
      check("start_fetch_old", 32'(instruction), 32'(old_w0));
    end
    fetch_req = hold_fetch;
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 2 == 1)) begin
        load_valid = 1'b0;
        load_data  = 16'hDEAD;
        load_last  = 1'b1;
        tick();
        if (load_done) done_cnt++;
        if (hold_fetch) check("hold_fetch_gap", 32'(instr_valid), 32'd0);
      end
      load_valid = 1'b1;
      load_data  = prog_buf[i];
      load_last  = use_last && (i == n - 1);
      tick();
      if (load_done) done_cnt++;
      if (hold_fetch) check("hold_fetch_beat", 32'(instr_valid), 32'd0);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    fetch_req  = 1'b0;
    check("busy_after_load", 32'(busy), 32'd0);
    tick();
    if (load_done) done_cnt++;
    check("load_done_once", 32'(done_cnt), 32'd1);
    for (int i = 0; i < n; i++) exp_mem[bank][i] = prog_buf[i];
    exp_len[bank] = n;
  endtask

  initial begin
    reset = 1'b1; bank_sel = '0; load_start = 0; load_valid = 0; load_last = 0;
    load_data = '0; fetch_req = 0; fetch_addr = '0;
    for (int b = 0; b < 4; b++) exp_len[b] = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instruction", 32'(instruction), 32'(NOP));
    check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);

    // Unloaded banks fault, including addresses beyond DEPTH
    fetch_chk(0, 0, "unloaded_b0");
    fetch_chk(3, 200, "unloaded_b3_far");

    // Bank 1: 12 words, word 10 = E7F9, last = BF00
    for (int i = 0; i < 12; i++) prog_buf[i] = 16'h1000 + 16'(i);
    prog_buf[10] = 16'hE7F9;
    prog_buf[11] = 16'hBF00;
    load_prog(1, 12, 1'b1, 1'b0, 1'b0, 1'b0);
    fetch_chk(1, 10, "b1_a10");
    check("b1_a10_word", 32'(instruction), 32'h0000E7F9);
    fetch_chk(1, 11, "b1_a11_nop_data");
    fetch_chk(1, 12, "b1_a12_fault");
    check("b1_a12_fault_hc", 32'(fetch_fault), 32'd1);
    tick();
    check("idle_valid_low", 32'(instr_valid), 32'd0);
    check("idle_instr_hold", 32'(instruction), 32'(NOP));

    // Banks 0 and 2, then alternating back-to-back fetches of addr 0
    for (int i = 0; i < 4; i++) prog_buf[i] = 16'h0A00 + 16'(i);
    load_prog(0, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) prog_buf[i] = 16'h2A00 + 16'(i);
    load_prog(2, 6, 1'b1, 1'b0, 1'b0, 1'b0);
    fetch_addr = 16'd0;
    fetch_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bank_sel = (k % 2 == 0) ? 2'd0 : 2'd2;
      tick();
      check("b2b_valid", 32'(instr_valid), 32'd1);
      check("b2b_instr", 32'(instruction), (k % 2 == 0) ? 32'h0A00 : 32'h2A00);
    end
    fetch_req = 1'b0;

    // Bank 3: DEPTH beats without load_last auto-terminates
    for (int i = 0; i < 128; i++) prog_buf[i] = 16'h3000 + 16'(i);
    load_prog(3, 128, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch_chk(3, 127, "b3_a127");
    check("b3_a127_word", 32'(instruction), 32'h0000307F);
    fetch_chk(3, 128, "b3_a128_nowrap");
    fetch_chk(3, 0, "b3_a0");

    // Reload bank 2 with gaps, fetch held through LOAD, fetch on load_start
    for (int i = 0; i < 3; i++) prog_buf[i] = 16'h2B00 + 16'(i);
    load_prog(2, 3, 1'b1, 1'b1, 1'b1, 1'b1);
    fetch_chk(2, 0, "b2_reload_a0");
    fetch_chk(2, 1, "b2_reload_a1");
    fetch_chk(2, 2, "b2_reload_a2");
    fetch_chk(2, 3, "b2_stale_a3");

    // Bank 0: load 8 words, then reset after 5 of 10 reload beats
    for (int i = 0; i < 8; i++) prog_buf[i] = 16'h0C00 + 16'(i);
    load_prog(0, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    bank_sel   = 2'd0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data  = 16'h0D00 + 16'(i);
      tick();
      check("abort_no_done", 32'(load_done), 32'd0);
    end
    load_valid = 1'b0;
    for (int i = 0; i < 5; i++) exp_mem[0][i] = 16'h0D00 + 16'(i);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_load_ready", 32'(load_ready), 32'd0);
    fetch_chk(0, 7, "abort_a7");
    check("abort_a7_word", 32'(instruction), 32'h00000C07);
    fetch_chk(0, 0, "abort_a0_partial");
    fetch_chk(0, 8, "abort_a8_fault");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
